// File: rtl/scancode_scheduler.sv
// ============================================================================
// Module   : scancode_scheduler
// Brief    : Strips PS/2 break/extended prefixes, queues make codes and
//            releases at most one per frame_tick as a flag pulse.
//            Optional feature macro: SCANCODE_REPEAT_FILTER_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scancode_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 2
) (
  input  logic          vga_clk,
  input  logic          reset,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  input  logic          frame_tick,
  input  logic          clr_ovf,
  output logic          flag,
  output logic [7:0]    scancode,
  output logic [AW:0]   fifo_level,
  output logic          overflow
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BRK     = 2'd1,
    S_EXT     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_make;
  logic            r_push_pend;
  logic [7:0]      r_push_data;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_full;
  logic            w_pop;
  logic            w_push_req;
  logic            w_push;
  logic            w_drop_full;

  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    if (rx_valid) begin
      case (r_state)
        S_IDLE: begin
          if (rx_data == 8'hF0)
            w_state_nxt = S_BRK;
          else if (rx_data == 8'hE0)
            w_state_nxt = S_EXT;
          else if (rx_data != 8'h00 && rx_data != 8'hFF)
            w_make = 1'b1;
        end
        S_BRK:   w_state_nxt = S_IDLE;
        S_EXT:   w_state_nxt = (rx_data == 8'hF0) ? S_EXT_BRK : S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_push_pend <= 1'b0;
      r_push_data <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_push_pend <= w_make;
      if (w_make)
        r_push_data <= rx_data;
    end
  end

`ifdef SCANCODE_REPEAT_FILTER_EN
  logic [7:0] r_held;
  logic       w_release;

  assign w_release  = rx_valid && (r_state == S_BRK);
  assign w_push_req = r_push_pend && (r_push_data != r_held);

  // Held code follows accepted pushes; a matching break clears it.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset)
      r_held <= 8'h00;
    else if (w_release && rx_data == r_held)
      r_held <= 8'h00;
    else if (w_push)
      r_held <= r_push_data;
  end
`else
  assign w_push_req = r_push_pend;
`endif

  assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop       = frame_tick && (r_count != '0);
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_drop_full = w_push_req && w_full && !w_pop;

  always_ff @(posedge vga_clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= r_push_data;
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      flag     <= 1'b0;
      scancode <= 8'h00;
      overflow <= 1'b0;
    end else begin
      flag <= w_pop;
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        scancode <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop_full)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

  assign fifo_level = r_count;

endmodule

`default_nettype wire

// File: tb/tb_scancode_scheduler.sv
// ============================================================================
// Module   : tb_scancode_scheduler
// Brief    : Scoreboarded random + directed bench for scancode_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scancode_scheduler;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef SCANCODE_REPEAT_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          frame_tick;
  logic          clr_ovf;
  logic          flag;
  logic [7:0]    scancode;
  logic [AW:0]   fifo_level;
  logic          overflow;

  scancode_scheduler #(.FIFO_DEPTH(DEPTH), .AW(AW)) dut (
    .vga_clk    (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .frame_tick (frame_tick),
    .clr_ovf    (clr_ovf),
    .flag       (flag),
    .scancode   (scancode),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of make codes plus the prefix seen so far.
  int  mq[$];
  int  exq[$];
  bit  pend;
  int  pend_b;
  bit  seen_ext;
  bit  seen_brk;
  int  held;
  bit  movf;
  int  last_sc;
  bit  chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exq.delete();
    pend = 0; pend_b = 0; seen_ext = 0; seen_brk = 0;
    held = 0; movf = 0; last_sc = 0;
  endtask

  task automatic model_step(input bit rxv, input int d, input bit tk, input bit clr);
    int  sz0;
    bit  popped;
    bit  setov;
    sz0 = mq.size();
    popped = 0;
    setov = 0;
    if (tk && sz0 > 0) begin
      last_sc = mq.pop_front();
      exq.push_back(last_sc);
      popped = 1;
    end
    if (pend) begin
      if (FILT && pend_b == held) begin
        // typematic repeat suppressed
      end else if (sz0 == DEPTH && !popped) begin
        setov = 1;
      end else begin
        mq.push_back(pend_b);
        held = pend_b;
      end
    end
    pend = 0;
    if (setov) movf = 1;
    else if (clr) movf = 0;
    if (rxv) begin
      if (seen_brk) begin
        if (!seen_ext && FILT && d == held) held = 0;
        seen_brk = 0; seen_ext = 0;
      end else if (seen_ext) begin
        if (d == 8'hF0) seen_brk = 1;
        else seen_ext = 0;
      end else if (d == 8'hF0) begin
        seen_brk = 1;
      end else if (d == 8'hE0) begin
        seen_ext = 1;
      end else if (d != 8'h00 && d != 8'hFF) begin
        pend = 1;
        pend_b = d;
      end
    end
  endtask

  // Monitor: flag must be present exactly when a popped code is awaited.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("flag", int'(flag), int'(exq.size() > 0));
      if (flag && exq.size() > 0)
        chk("flag_code", int'(scancode), exq.pop_front());
      chk("fifo_level", int'(fifo_level), mq.size());
      chk("overflow", int'(overflow), int'(movf));
      chk("scancode_hold", int'(scancode), last_sc);
    end
  end

  task automatic cycle(input bit rxv, input int d, input bit tk, input bit clr);
    rx_valid   = rxv;
    rx_data    = 8'(d);
    frame_tick = tk;
    clr_ovf    = clr;
    @(posedge clk);
    model_step(rxv, d, tk, clr);
    @(negedge clk);
  endtask

  task automatic send(input int b);
    cycle(1, b, 0, 0);
    cycle(0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_flag"},  int'(flag), 0);
    chk({nm, "_code"},  int'(scancode), 0);
    chk({nm, "_level"}, int'(fifo_level), 0);
    chk({nm, "_ovf"},   int'(overflow), 0);
  endtask

  initial begin
    int codes[4];
    int b;
    codes[0] = 8'h2B; codes[1] = 8'h15; codes[2] = 8'h33; codes[3] = 8'h22;
    model_reset();
    reset = 1; rx_valid = 0; rx_data = 0; frame_tick = 0; clr_ovf = 0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 0;
    chk_en = 1;

    send(8'h2B); ticks(1);
    send(8'h15); send(8'hF0); send(8'h15); send(8'h33); ticks(3);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); ticks(1);
    send(8'h2B); send(8'h15); send(8'h33); send(8'h22); send(8'h2D);
    cycle(0, 0, 0, 1); ticks(4);
    send(8'h2B); send(8'h2B); ticks(1); send(8'h2B); send(8'hF0); send(8'h2B);
    send(8'h2B); ticks(5);
    send(8'h00); send(8'hFF); send(8'h15); ticks(2);

    // Reset in the middle of a break sequence.
    cycle(1, 8'hF0, 0, 0);
    reset = 1;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    @(negedge clk);
    reset = 0;
    send(8'h34); ticks(1);

    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 15);
      if (r < 2)       b = 8'hF0;
      else if (r == 2) b = 8'hE0;
      else if (r == 3) b = 8'h00;
      else if (r == 4) b = 8'hFF;
      else             b = codes[$urandom_range(0, 3)];
      cycle(1, b, ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
      for (int g = 0; g < $urandom_range(1, 3); g++)
        cycle(0, 0, ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
    end

    ticks(DEPTH + 2);
    cycle(0, 0, 0, 0);
    chk("drain_empty", exq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
